l1_lc_arbiter: RTL and testbench

Two-port arbiter between the L1 data cache and L1 instruction cache and the single lower-cache (LC) line interface. Grants one line request at a time to the LC with round-robin fairness and holds it stable until LC acceptance. Tracks outstanding reads in issue order and steers each in-order LC read response back to the requester that issued it.

---
 rtl/l1_lc_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_l1_lc_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_lc_arbiter.sv
// Round-robin arbiter between the L1D (port 0) and L1I (port 1) and the single lower-cache line port.
// Read responses return in issue order; an ID FIFO records which port each outstanding read belongs to.
module l1_lc_arbiter #(
    parameter int PADDR_BITS      = 22,
    parameter int LINE_BITS       = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [PADDR_BITS-1:0] req0_addr_in,
    input  logic [LINE_BITS-1:0]  req0_value_in,
    input  logic                  req0_we_in,
    output logic                  resp0_valid_out,
    input  logic                  resp0_ready_in,
    output logic [PADDR_BITS-1:0] resp0_addr_out,
    output logic [LINE_BITS-1:0]  resp0_value_out,

    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [PADDR_BITS-1:0] req1_addr_in,
    input  logic [LINE_BITS-1:0]  req1_value_in,
    input  logic                  req1_we_in,
    output logic                  resp1_valid_out,
    input  logic                  resp1_ready_in,
    output logic [PADDR_BITS-1:0] resp1_addr_out,
    output logic [LINE_BITS-1:0]  resp1_value_out,

    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [LINE_BITS-1:0]  lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [LINE_BITS-1:0]  lc_value_in,

    output logic                  err_out
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    state_t                state_reg, state_next;
    logic                  rr_reg, rr_next;

    logic [1:0]            req_valid, req_we, eligible, req_ready, resp_ready, resp_valid;
    logic [PADDR_BITS-1:0] req_addr  [2];
    logic [LINE_BITS-1:0]  req_value [2];

    logic                  grant_valid, grant_sel;
    logic                  push, pop;

    logic                  id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  fifo_full, fifo_empty, head_id;

    logic [PADDR_BITS-1:0] lc_addr_reg;
    logic [LINE_BITS-1:0]  lc_value_reg;
    logic                  lc_we_reg;
    logic                  err_reg;

    assign req_valid    = {req1_valid_in, req0_valid_in};
    assign req_we       = {req1_we_in, req0_we_in};
    assign resp_ready   = {resp1_ready_in, resp0_ready_in};
    assign req_addr[0]  = req0_addr_in;
    assign req_addr[1]  = req1_addr_in;
    assign req_value[0] = req0_value_in;
    assign req_value[1] = req1_value_in;

    // Full is taken from registered occupancy, so a pop only frees a slot next cycle.
    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign head_id    = id_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign eligible[gi]   = req_valid[gi] && (req_we[gi] || !fifo_full);
            assign req_ready[gi]  = grant_valid && (grant_sel == 1'(gi));
            assign resp_valid[gi] = lc_valid_in && !fifo_empty && (head_id == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        rr_next     = rr_reg;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_valid = |eligible;
                grant_sel   = (eligible == 2'b11) ? rr_reg : eligible[1];
                if (grant_valid) begin
                    state_next = ISSUE;
                    rr_next    = ~grant_sel;
                end
            end
            ISSUE: begin
                if (lc_ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push = grant_valid && !req_we[grant_sel];
    assign pop  = lc_valid_in && lc_ready_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            rr_reg       <= 1'b0;
            lc_addr_reg  <= '0;
            lc_value_reg <= '0;
            lc_we_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            if (grant_valid) begin
                lc_addr_reg  <= req_addr[grant_sel];
                lc_value_reg <= req_value[grant_sel];
                lc_we_reg    <= req_we[grant_sel];
            end
            if (lc_valid_in && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk_in) begin
        if (push) begin
            id_mem[wr_ptr_reg] <= grant_sel;
        end
    end

    assign req0_ready_out  = req_ready[0];
    assign req1_ready_out  = req_ready[1];

    assign lc_ready_out    = !fifo_empty && resp_ready[head_id];
    assign resp0_valid_out = resp_valid[0];
    assign resp1_valid_out = resp_valid[1];
    assign resp0_addr_out  = lc_addr_in;
    assign resp1_addr_out  = lc_addr_in;
    assign resp0_value_out = lc_value_in;
    assign resp1_value_out = lc_value_in;

    assign lc_valid_out    = (state_reg == ISSUE);
    assign lc_addr_out     = lc_addr_reg;
    assign lc_value_out    = lc_value_reg;
    assign lc_we_out       = lc_we_reg;
    assign err_out         = err_reg;

endmodule

// File: tb/tb_l1_lc_arbiter.sv
// Directed bench for l1_lc_arbiter: grant order, LC hold, ID FIFO limits and response routing.
module tb_l1_lc_arbiter;

    localparam int PADDR_BITS = 22;
    localparam int LINE_BITS  = 512;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    logic                  req0_valid_in, req0_ready_out, req0_we_in;
    logic [PADDR_BITS-1:0] req0_addr_in;
    logic [LINE_BITS-1:0]  req0_value_in;
    logic                  resp0_valid_out, resp0_ready_in;
    logic [PADDR_BITS-1:0] resp0_addr_out;
    logic [LINE_BITS-1:0]  resp0_value_out;
    logic                  req1_valid_in, req1_ready_out, req1_we_in;
    logic [PADDR_BITS-1:0] req1_addr_in;
    logic [LINE_BITS-1:0]  req1_value_in;
    logic                  resp1_valid_out, resp1_ready_in;
    logic [PADDR_BITS-1:0] resp1_addr_out;
    logic [LINE_BITS-1:0]  resp1_value_out;
    logic                  lc_valid_out, lc_ready_in, lc_we_out;
    logic [PADDR_BITS-1:0] lc_addr_out;
    logic [LINE_BITS-1:0]  lc_value_out;
    logic                  lc_valid_in, lc_ready_out;
    logic [PADDR_BITS-1:0] lc_addr_in;
    logic [LINE_BITS-1:0]  lc_value_in;
    logic                  err_out;

    int tests_run    = 0;
    int tests_failed = 0;

    l1_lc_arbiter #(
        .PADDR_BITS(PADDR_BITS), .LINE_BITS(LINE_BITS), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out), .req0_addr_in(req0_addr_in),
        .req0_value_in(req0_value_in), .req0_we_in(req0_we_in),
        .resp0_valid_out(resp0_valid_out), .resp0_ready_in(resp0_ready_in),
        .resp0_addr_out(resp0_addr_out), .resp0_value_out(resp0_value_out),
        .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out), .req1_addr_in(req1_addr_in),
        .req1_value_in(req1_value_in), .req1_we_in(req1_we_in),
        .resp1_valid_out(resp1_valid_out), .resp1_ready_in(resp1_ready_in),
        .resp1_addr_out(resp1_addr_out), .resp1_value_out(resp1_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
        .lc_value_in(lc_value_in), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid_in = 0; req0_we_in = 0; req0_addr_in = '0; req0_value_in = '0;
        req1_valid_in = 0; req1_we_in = 0; req1_addr_in = '0; req1_value_in = '0;
        resp0_ready_in = 0; resp1_ready_in = 0;
        lc_ready_in = 0; lc_valid_in = 0; lc_addr_in = '0; lc_value_in = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_in = 1;
        tick();
        tick();
        rst_in = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        tests_run++;
        if (lc_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_lc_valid got %0b want 0", lc_valid_out); end
        tests_run++;
        if (lc_addr_out !== '0 || lc_we_out !== 1'b0 || lc_value_out !== '0) begin
            tests_failed++; $display("FAIL reset_lc_regs got addr=%h we=%0b want 0", lc_addr_out, lc_we_out);
        end
        tests_run++;
        if (err_out !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %0b want 0", err_out); end
        tests_run++;
        if ({req0_ready_out, req1_ready_out, resp0_valid_out, resp1_valid_out, lc_ready_out} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshakes got %b want 00000",
                     {req0_ready_out, req1_ready_out, resp0_valid_out, resp1_valid_out, lc_ready_out});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_read();
        req0_valid_in = 1; req0_addr_in = 22'h00040; req0_we_in = 0;
        #1;
        tests_run++;
        if (req0_ready_out !== 1'b1 || req1_ready_out !== 1'b0) begin
            tests_failed++; $display("FAIL single_grant got r0=%0b r1=%0b want 1 0", req0_ready_out, req1_ready_out);
        end
        tick();
        req0_valid_in = 0;
        tests_run++;
        if (lc_valid_out !== 1'b1 || lc_addr_out !== 22'h00040 || lc_we_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_issue got v=%0b addr=%h we=%0b want 1 00040 0", lc_valid_out, lc_addr_out, lc_we_out);
        end
        lc_ready_in = 1;
        tick();
        lc_ready_in = 0;
        lc_valid_in = 1; lc_addr_in = 22'h00040; lc_value_in = 512'hDEADBEEF;
        resp0_ready_in = 1; resp1_ready_in = 1;
        #1;
        tests_run++;
        if (resp0_valid_out !== 1'b1 || resp1_valid_out !== 1'b0 || lc_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_resp_route got r0=%0b r1=%0b lcr=%0b want 1 0 1",
                     resp0_valid_out, resp1_valid_out, lc_ready_out);
        end
        tests_run++;
        if (resp0_value_out !== 512'hDEADBEEF || resp0_addr_out !== 22'h00040) begin
            tests_failed++; $display("FAIL single_resp_data got %h want deadbeef", resp0_value_out[31:0]);
        end
        tick();
        lc_valid_in = 0;
        #1;
        tests_run++;
        if (lc_ready_out !== 1'b0) begin tests_failed++; $display("FAIL single_fifo_empty got lc_ready=%0b want 0", lc_ready_out); end
        $display("[TB] single read 0x00040 done");
    endtask

    task automatic test_contention();
        logic [PADDR_BITS-1:0] addr_a = 22'h00100;
        logic [PADDR_BITS-1:0] addr_b = 22'h00200;
        logic exp;
        apply_reset();
        req0_valid_in = 1; req0_addr_in = addr_a;
        req1_valid_in = 1; req1_addr_in = addr_b;
        lc_ready_in = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1);
            tests_run++;
            if (req0_ready_out !== !exp || req1_ready_out !== exp) begin
                tests_failed++;
                $display("FAIL contention_grant%0d got r0=%0b r1=%0b want port %0d", i, req0_ready_out, req1_ready_out, exp);
            end
            tick();
            if (i == 3) begin req0_valid_in = 0; req1_valid_in = 0; end
            tests_run++;
            if (lc_valid_out !== 1'b1 || lc_addr_out !== (exp ? addr_b : addr_a) ||
                req0_ready_out !== 1'b0 || req1_ready_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL contention_issue%0d got v=%0b addr=%h", i, lc_valid_out, lc_addr_out);
            end
            tick();
            $display("[TB] contention grant %0d to port %0d", i, exp);
        end
        lc_ready_in = 0;
        lc_valid_in = 1; resp0_ready_in = 1; resp1_ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 1);
            lc_addr_in = exp ? addr_b : addr_a;
            #1;
            tests_run++;
            if (resp0_valid_out !== !exp || resp1_valid_out !== exp || lc_ready_out !== 1'b1) begin
                tests_failed++;
                $display("FAIL contention_resp%0d got r0=%0b r1=%0b lcr=%0b want port %0d",
                         i, resp0_valid_out, resp1_valid_out, lc_ready_out, exp);
            end
            tick();
        end
        lc_valid_in = 0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        req1_valid_in = 1; req1_we_in = 1; req1_addr_in = 22'h00300; req1_value_in = 512'h55;
        tick();
        req1_addr_in = 22'h3FFFF; req1_value_in = 512'hAA; req1_we_in = 0;
        req0_valid_in = 1; req0_addr_in = 22'h00500;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests_run++;
            if (lc_valid_out !== 1'b1 || lc_addr_out !== 22'h00300 || lc_value_out !== 512'h55 || lc_we_out !== 1'b1 ||
                req0_ready_out !== 1'b0 || req1_ready_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold%0d got v=%0b addr=%h we=%0b r0=%0b r1=%0b",
                         c, lc_valid_out, lc_addr_out, lc_we_out, req0_ready_out, req1_ready_out);
            end
            tick();
        end
        lc_ready_in = 1;
        tick();
        lc_ready_in = 0;
        tests_run++;
        if (req0_ready_out !== 1'b1 || req1_ready_out !== 1'b0) begin
            tests_failed++; $display("FAIL backpressure_rr got r0=%0b r1=%0b want 1 0", req0_ready_out, req1_ready_out);
        end
        req0_valid_in = 0; req1_valid_in = 0;
        $display("[TB] backpressure held 5 cycles");
    endtask

    task automatic test_fifo_full();
        apply_reset();
        resp0_ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            req0_valid_in = 1; req0_addr_in = 22'(32'h10 + i);
            #1;
            tests_run++;
            if (req0_ready_out !== 1'b1) begin tests_failed++; $display("FAIL full_fill%0d got ready=%0b want 1", i, req0_ready_out); end
            tick();
            req0_valid_in = 0; lc_ready_in = 1;
            tick();
            lc_ready_in = 0;
        end
        req0_valid_in = 1; req0_addr_in = 22'h00099; req0_we_in = 0;
        req1_valid_in = 1; req1_addr_in = 22'h00077; req1_we_in = 1;
        #1;
        tests_run++;
        if (req0_ready_out !== 1'b0 || req1_ready_out !== 1'b1) begin
            tests_failed++; $display("FAIL full_write_bypass got r0=%0b r1=%0b want 0 1", req0_ready_out, req1_ready_out);
        end
        tick();
        req1_valid_in = 0;
        tests_run++;
        if (lc_we_out !== 1'b1 || lc_addr_out !== 22'h00077) begin
            tests_failed++; $display("FAIL full_write_issue got we=%0b addr=%h want 1 00077", lc_we_out, lc_addr_out);
        end
        lc_ready_in = 1;
        tick();
        lc_ready_in = 0;
        lc_valid_in = 1; lc_addr_in = 22'h00010;
        #1;
        tests_run++;
        if (req0_ready_out !== 1'b0 || lc_ready_out !== 1'b1 || resp0_valid_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_blocked got r0=%0b lcr=%0b resp0=%0b want 0 1 1", req0_ready_out, lc_ready_out, resp0_valid_out);
        end
        tick();
        lc_valid_in = 0;
        #1;
        tests_run++;
        if (req0_ready_out !== 1'b1) begin tests_failed++; $display("FAIL full_unblock got r0=%0b want 1", req0_ready_out); end
        tick();
        req0_valid_in = 0;
        tests_run++;
        if (lc_addr_out !== 22'h00099 || lc_we_out !== 1'b0) begin
            tests_failed++; $display("FAIL full_late_issue got addr=%h want 00099", lc_addr_out);
        end
        lc_ready_in = 1;
        tick();
        lc_ready_in = 0;
        lc_valid_in = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (resp0_valid_out !== 1'b1 || lc_ready_out !== 1'b1) begin
                tests_failed++; $display("FAIL full_drain%0d got resp0=%0b lcr=%0b want 1 1", i, resp0_valid_out, lc_ready_out);
            end
            tick();
        end
        lc_valid_in = 0;
        #1;
        tests_run++;
        if (lc_ready_out !== 1'b0) begin tests_failed++; $display("FAIL full_drained got lcr=%0b want 0", lc_ready_out); end
        $display("[TB] fifo full scenario done");
    endtask

    task automatic test_resp_stall();
        apply_reset();
        req1_valid_in = 1; req1_addr_in = 22'h00400;
        tick();
        req1_valid_in = 0; lc_ready_in = 1;
        tick();
        lc_ready_in = 0;
        lc_valid_in = 1; lc_addr_in = 22'h00400; resp0_ready_in = 1; resp1_ready_in = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (lc_ready_out !== 1'b0 || resp1_valid_out !== 1'b1 || resp0_valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall%0d got lcr=%0b r1=%0b r0=%0b want 0 1 0", c, lc_ready_out, resp1_valid_out, resp0_valid_out);
            end
            tick();
        end
        resp1_ready_in = 1;
        #1;
        tests_run++;
        if (lc_ready_out !== 1'b1 || resp1_addr_out !== 22'h00400) begin
            tests_failed++; $display("FAIL stall_release got lcr=%0b addr=%h want 1 00400", lc_ready_out, resp1_addr_out);
        end
        tick();
        lc_valid_in = 0;
        #1;
        tests_run++;
        if (lc_ready_out !== 1'b0 || err_out !== 1'b0) begin
            tests_failed++; $display("FAIL stall_popped got lcr=%0b err=%0b want 0 0", lc_ready_out, err_out);
        end
        $display("[TB] response stall on port 1 done");
    endtask

    task automatic test_spurious_reset();
        lc_valid_in = 1; resp0_ready_in = 1; resp1_ready_in = 1;
        #1;
        tests_run++;
        if (lc_ready_out !== 1'b0 || resp0_valid_out !== 1'b0 || resp1_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_route got lcr=%0b r0=%0b r1=%0b want 0 0 0", lc_ready_out, resp0_valid_out, resp1_valid_out);
        end
        tick();
        lc_valid_in = 0;
        tick();
        tests_run++;
        if (err_out !== 1'b1) begin tests_failed++; $display("FAIL spurious_err_sticky got %0b want 1", err_out); end
        req0_valid_in = 1; req0_we_in = 0; req0_addr_in = 22'h00600;
        tick();
        req0_valid_in = 0;
        tests_run++;
        if (lc_valid_out !== 1'b1) begin tests_failed++; $display("FAIL spurious_issue got %0b want 1", lc_valid_out); end
        rst_in = 1;
        tick();
        rst_in = 0;
        tests_run++;
        if (lc_valid_out !== 1'b0 || err_out !== 1'b0 || lc_addr_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_issue got v=%0b err=%0b addr=%h want 0 0 0", lc_valid_out, err_out, lc_addr_out);
        end
        tests_run++;
        if (lc_ready_out !== 1'b0) begin tests_failed++; $display("FAIL reset_discard_ids got lcr=%0b want 0", lc_ready_out); end
        $display("[TB] spurious response and mid-issue reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_fifo_full();
        test_resp_stall();
        test_spurious_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
